count_seq_checker: RTL and testbench

//  Receive-side partner of the up/down counter: consumes the counter's count bus, infers
//  the count direction, and flags illegal transitions and wrap events. Sits beside the

---
 rtl/counter_pkg.sv | 23 ++
 rtl/count_seq_checker_step_classifier.sv | 32 +++
 rtl/count_seq_checker.sv | 162 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the count sequence checker.
// Holds FSM state codes, step classes and default widths.
package counter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_ERR_W = 8;
  localparam int DEF_LAP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACQ       = 2'd1,
    ST_LOCK_UP   = 2'd2,
    ST_LOCK_DOWN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_HOLD = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

endpackage

// File: rtl/count_seq_checker_step_classifier.sv
// Combinational step classifier: (count_i - prev_i) mod 2^WIDTH.
// Ports: prev_i, count_i in; class_o (UP/DOWN/HOLD/BAD) out.
module step_classifier
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output step_e            class_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] step;

  // Natural WIDTH-bit truncation gives the modulo.
  assign step = count_i - prev_i;

  always_comb begin
    class_o = STEP_BAD;
    if (step == ONE) begin
      class_o = STEP_UP;
    end else if (step == ALL) begin
      class_o = STEP_DOWN;
    end else if (step == '0) begin
      class_o = STEP_HOLD;
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Sequence monitor for a mod-2^WIDTH up/down counter.
// Ports: clk, reset, sample_en, count_in in; locked, dir_up,
// dir_chg, wrap, err, err_count, lap_count out (all registered).
module count_seq_checker
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W,
  parameter int LAP_W = DEF_LAP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir_up,
  output logic             dir_chg,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [LAP_W-1:0] lap_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic             locked_q;
  logic             dir_up_q;
  logic             dir_chg_q;
  logic             wrap_q;
  logic             err_q;
  logic [ERR_W-1:0] err_count_q;
  logic [LAP_W-1:0] lap_count_q;

  step_e            step_cls;
  logic             wrap_up;
  logic             wrap_dn;
  logic             err_sat;

  step_classifier #(
    .WIDTH (WIDTH)
  ) u_cls (
    .prev_i  (prev_q),
    .count_i (count_in),
    .class_o (step_cls)
  );

  assign wrap_up = (prev_q == CNT_MAX) &&
                   (count_in == '0);
  assign wrap_dn = (prev_q == '0) &&
                   (count_in == CNT_MAX);
  assign err_sat = (err_count_q == {ERR_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      locked_q    <= 1'b0;
      dir_up_q    <= 1'b0;
      dir_chg_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      lap_count_q <= '0;
    end else begin
      dir_chg_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      if (sample_en) begin
        prev_q <= count_in;
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQ;
          end
          ST_ACQ: begin
            unique case (step_cls)
              STEP_UP: begin
                state_q  <= ST_LOCK_UP;
                locked_q <= 1'b1;
                dir_up_q <= 1'b1;
              end
              STEP_DOWN: begin
                state_q  <= ST_LOCK_DOWN;
                locked_q <= 1'b1;
                dir_up_q <= 1'b0;
              end
              STEP_HOLD: begin
              end
              STEP_BAD: begin
                err_q <= 1'b1;
                if (!err_sat) begin
                  err_count_q <= err_count_q + ERR_W'(1);
                end
              end
            endcase
          end
          ST_LOCK_UP: begin
            unique case (step_cls)
              STEP_UP: begin
                if (wrap_up) begin
                  wrap_q      <= 1'b1;
                  lap_count_q <= lap_count_q + LAP_W'(1);
                end
              end
              STEP_DOWN: begin
                state_q   <= ST_LOCK_DOWN;
                dir_up_q  <= 1'b0;
                dir_chg_q <= 1'b1;
              end
              STEP_HOLD: begin
              end
              STEP_BAD: begin
                // dir_up keeps its last value in ACQ
                state_q  <= ST_ACQ;
                locked_q <= 1'b0;
                err_q    <= 1'b1;
                if (!err_sat) begin
                  err_count_q <= err_count_q + ERR_W'(1);
                end
              end
            endcase
          end
          ST_LOCK_DOWN: begin
            unique case (step_cls)
              STEP_DOWN: begin
                if (wrap_dn) begin
                  wrap_q      <= 1'b1;
                  lap_count_q <= lap_count_q + LAP_W'(1);
                end
              end
              STEP_UP: begin
                state_q   <= ST_LOCK_UP;
                dir_up_q  <= 1'b1;
                dir_chg_q <= 1'b1;
              end
              STEP_HOLD: begin
              end
              STEP_BAD: begin
                state_q  <= ST_ACQ;
                locked_q <= 1'b0;
                err_q    <= 1'b1;
                if (!err_sat) begin
                  err_count_q <= err_count_q + ERR_W'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign dir_up    = dir_up_q;
  assign dir_chg   = dir_chg_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign lap_count = lap_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with a behavioural model.
// Every driven cycle is compared against the model, plus literal pins.
module tb_count_seq_checker;

  localparam int W  = 3;
  localparam int M  = 1 << W;
  localparam int EW = 8;
  localparam int LW = 8;

  logic          clk;
  logic          reset;
  logic          sample_en;
  logic [W-1:0]  count_in;
  logic          locked;
  logic          dir_up;
  logic          dir_chg;
  logic          wrap;
  logic          err;
  logic [EW-1:0] err_count;
  logic [LW-1:0] lap_count;

  int checks = 0;
  int errors = 0;

  // model: seen = a sample has been captured since reset
  bit m_seen, m_lk, m_up, m_chg, m_wrap, m_err;
  int m_prev, m_ec, m_lc;

  count_seq_checker #(
    .WIDTH (W),
    .ERR_W (EW),
    .LAP_W (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .count_in  (count_in),
    .locked    (locked),
    .dir_up    (dir_up),
    .dir_chg   (dir_chg),
    .wrap      (wrap),
    .err       (err),
    .err_count (err_count),
    .lap_count (lap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit en, input int c);
    int s;
    m_chg  = 0;
    m_wrap = 0;
    m_err  = 0;
    if (r) begin
      m_seen = 0; m_lk = 0; m_up = 0;
      m_prev = 0; m_ec = 0; m_lc = 0;
    end else if (en) begin
      s = (c - m_prev + M) % M;
      if (!m_seen) begin
        m_seen = 1;
      end else if (s == 0) begin
      end else if (s != 1 && s != M - 1) begin
        m_err = 1;
        m_lk  = 0;
        if (m_ec < (1 << EW) - 1) m_ec++;
      end else if (!m_lk) begin
        m_lk = 1;
        m_up = (s == 1);
      end else if (m_up != (s == 1)) begin
        m_chg = 1;
        m_up  = (s == 1);
      end else if ((m_up && c == 0) ||
                   (!m_up && c == M - 1)) begin
        m_wrap = 1;
        m_lc   = (m_lc + 1) % (1 << LW);
      end
      m_prev = c;
    end
  endtask

  task automatic compare();
    chk("locked", int'(locked), int'(m_lk));
    if (m_lk) chk("dir_up", int'(dir_up), int'(m_up));
    chk("dir_chg", int'(dir_chg), int'(m_chg));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("err", int'(err), int'(m_err));
    chk("err_count", int'(err_count), m_ec);
    chk("lap_count", int'(lap_count), m_lc);
  endtask

  task automatic cyc(input bit r, input bit en, input int c);
    @(negedge clk);
    reset     = r;
    sample_en = en;
    count_in  = W'(c);
    @(posedge clk);
    model(r, en, c);
    #1;
    compare();
  endtask

  task automatic smp(input int c);
    cyc(1'b0, 1'b1, c);
  endtask

  initial begin
    reset = 1'b1;
    sample_en = 1'b1;
    count_in = '0;
    m_seen = 0; m_lk = 0; m_up = 0;
    m_chg = 0; m_wrap = 0; m_err = 0;
    m_prev = 0; m_ec = 0; m_lc = 0;

    // 1: reset with count_in=5
    cyc(1'b1, 1'b1, 5);
    cyc(1'b1, 1'b1, 5);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ecnt", int'(err_count), 0);
    chk("rst_lcnt", int'(lap_count), 0);

    // 2: up 0..7,0,1
    smp(0);
    chk("first_no_lock", int'(locked), 0);
    smp(1);
    chk("lock_up", int'(locked), 1);
    chk("dir_up1", int'(dir_up), 1);
    for (int i = 2; i < 8; i++) smp(i);
    smp(0);
    chk("wrap_up", int'(wrap), 1);
    smp(1);
    chk("lap1", int'(lap_count), 1);
    chk("ecnt0", int'(err_count), 0);

    // 3: up to 4, then down through wrap
    smp(2); smp(3); smp(4);
    smp(3);
    chk("dirchg", int'(dir_chg), 1);
    chk("dir_dn", int'(dir_up), 0);
    smp(2);
    chk("dirchg_once", int'(dir_chg), 0);
    smp(1); smp(0); smp(7);
    chk("wrap_dn", int'(wrap), 1);
    chk("lap2", int'(lap_count), 2);

    // 4: lock up at 2, jump to 6
    smp(0); smp(1); smp(2);
    chk("relock_up", int'(dir_up), 1);
    smp(6);
    chk("bad_err", int'(err), 1);
    chk("bad_ecnt", int'(err_count), 1);
    chk("bad_unlock", int'(locked), 0);
    smp(7);
    chk("relock", int'(locked), 1);
    smp(0);
    chk("wrap_relock", int'(wrap), 1);

    // 5: sample_en gating and HOLD
    smp(1); smp(2); smp(3);
    cyc(1'b0, 1'b0, 6);
    cyc(1'b0, 1'b0, 1);
    cyc(1'b0, 1'b1, 4);
    chk("gate_noerr", int'(err), 0);
    chk("gate_ecnt", int'(err_count), 1);
    smp(4); smp(4);
    chk("hold_lock", int'(locked), 1);

    // 6: saturate error counter, then reset
    for (int i = 0; i < 300; i++) smp((i % 2 == 0) ? 0 : 4);
    chk("sat", int'(err_count), 255);
    cyc(1'b1, 1'b1, 3);
    chk("rst_mid_ecnt", int'(err_count), 0);
    chk("rst_mid_lock", int'(locked), 0);
    smp(5);
    chk("post_rst_err", int'(err), 0);
    smp(6);
    chk("post_rst_lock", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
